// File: rtl/cpu_paddle.sv
// CPU-controlled right paddle: centres while the ball recedes, waits a reaction delay, then tracks ball_y.
// paddle_y updates on the clk edge of a move_tick cycle; state changes on any clk edge.
module cpu_paddle #(
   parameter int MAX_STEP    = 3,
   parameter int REACT_DELAY = 8,
   parameter int DEADBAND    = 4,
   parameter int RESET_Y     = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       move_tick,
   input  logic [9:0] ball_x,
   input  logic [8:0] ball_y,
   input  logic       ball_direction,
   input  logic [5:0] ball_width,
   input  logic [5:0] wall_width,
   input  logic [8:0] paddle_length,
   output logic [8:0] paddle_y,
   output logic [1:0] cpu_state
);

   typedef enum logic [1:0] {
      CENTER = 2'b00,
      REACT  = 2'b01,
      TRACK  = 2'b10
   } state_t;

   localparam logic signed [10:0] MAX_STEP_S = 11'(MAX_STEP);
   localparam logic signed [10:0] DEADBAND_S = 11'(DEADBAND);

   state_t            state, state_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic [8:0]        y_nxt;

   logic signed [10:0] half_ball, half_len, clamp_lo, clamp_hi;
   logic signed [10:0] track_c, center_c, target, paddle_s;
   logic signed [10:0] err, abs_err, step, moved;
   logic               unused_bits;

   function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                                input logic signed [10:0] lo,
                                                input logic signed [10:0] hi);
      if (v < lo)
         return lo;
      else if (v > hi)
         return hi;
      else
         return v;
   endfunction

   // Signed 11-bit keeps small ball_y minus half the paddle from wrapping.
   assign half_ball = signed'({6'b0, ball_width[5:1]});
   assign half_len  = signed'({3'b0, paddle_length[8:1]});
   assign clamp_lo  = signed'({5'b0, wall_width});
   assign clamp_hi  = 11'sd480 - clamp_lo - signed'({2'b0, paddle_length});
   assign track_c   = clamp(signed'({2'b0, ball_y}) + half_ball - half_len, clamp_lo, clamp_hi);
   assign center_c  = clamp(11'sd240 - half_len, clamp_lo, clamp_hi);

   assign target   = (state == TRACK) ? track_c : center_c;
   assign paddle_s = signed'({2'b0, paddle_y});
   assign err      = target - paddle_s;
   assign abs_err  = (err < 0) ? -err : err;
   assign step     = (abs_err > MAX_STEP_S) ? MAX_STEP_S : abs_err;
   assign moved    = (err < 0) ? paddle_s - step : paddle_s + step;

   assign unused_bits = ^{ball_x, ball_width[0], paddle_length[0], moved[10:9]};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      y_nxt     = paddle_y;

      if (move_tick && state != REACT && abs_err > DEADBAND_S)
         y_nxt = moved[8:0];

      if (ball_direction) begin
         state_nxt = CENTER;
         cnt_nxt   = '0;
      end else begin
         case (state)
            CENTER: begin
               state_nxt = REACT;
               cnt_nxt   = 8'(REACT_DELAY);
            end
            REACT: begin
               // A count of 0 (zero reaction delay) also leaves on the first tick.
               if (move_tick) begin
                  if (cnt <= 8'd1) begin
                     state_nxt = TRACK;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt - 8'd1;
                  end
               end
            end
            TRACK:   state_nxt = TRACK;
            default: state_nxt = CENTER;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CENTER;
         cnt      <= '0;
         paddle_y <= 9'(RESET_Y);
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         paddle_y <= y_nxt;
      end
   end

   assign cpu_state = state;

endmodule

// File: doc/cpu_paddle.md
Name: cpu_paddle

Overview:
- Computer-controlled right-paddle driver for the 640x480 pong playfield.
- Consumes the ball block's upper-left coordinates and horizontal direction.
- Produces the right paddle's top Y coordinate, which feeds back into the ball block's collision logic.
- Reacts after a programmable delay and moves with a capped speed, so the CPU is beatable.

Parameters:
- MAX_STEP, 3: maximum pixels the paddle moves per move_tick.
- REACT_DELAY, 8: move_ticks the paddle stays frozen after the ball turns toward it.
- DEADBAND, 4: no movement while |target - paddle_y| <= DEADBAND.
- RESET_Y, 200: paddle_y value loaded on reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- move_tick  input  1  one-clk pulse per frame; all movement and counting happen only on cycles where this is high.
- ball_x  input  10  ball upper-left X (unused for decisions; reserved for future anticipation logic).
- ball_y  input  9  ball upper-left Y.
- ball_direction  input  1  0 = ball moving right (toward CPU paddle), 1 = moving left.
- ball_width  input  6  ball side length in pixels.
- wall_width  input  6  top/bottom wall thickness.
- paddle_length  input  9  paddle height in pixels.
- paddle_y  output  9  paddle top Y, registered.
- cpu_state  output  2  00 CENTER, 01 REACT, 10 TRACK (debug/LED).

Behaviour:
- Reset (async, active-high):
  - paddle_y = RESET_Y, cpu_state = CENTER, reaction counter = 0.
  - Reset asserted mid-operation overrides everything immediately.
- Target arithmetic, done in signed 11-bit to avoid underflow:
  - track_target = ball_y + (ball_width>>1) - (paddle_length>>1).
  - center_target = 240 - (paddle_length>>1).
  - Both are clamped to [wall_width, 480 - wall_width - paddle_length].
  - Clamping is combinational; only paddle_y is registered.
- Movement, applied on a move_tick cycle in CENTER or TRACK state:
  - err = target - paddle_y, where target = center_target in CENTER and track_target in TRACK.
  - If |err| <= DEADBAND: hold.
  - Else: paddle_y += sign(err) * min(|err|, MAX_STEP).
  - paddle_y therefore never leaves the clamped range, provided it started inside it.
- State machine (all transitions evaluated on clk edges):
  - Priority 1, any state: ball_direction = 1 -> CENTER next cycle; counter cleared. This applies independent of move_tick.
  - CENTER:
    - If ball_direction = 0 -> REACT; counter loaded with REACT_DELAY.
    - The movement step for that cycle still uses center_target.
  - REACT:
    - paddle_y frozen.
    - On each move_tick, counter decrements.
    - On a move_tick with counter == 1 -> TRACK; counter becomes 0.
    - With REACT_DELAY = 0, REACT exits on its first move_tick.
  - TRACK: follows track_target every move_tick while ball_direction = 0.
- Boundary cases:
  - move_tick low: no movement and no counter change; direction-driven state changes still occur.
  - ball_y near 0 or 479: target saturates at the clamp limits; no wrap.
  - Serve (ball block resets the ball to center with direction 0): treated as a normal approach, i.e. CENTER -> REACT.
- Latency: paddle_y updates on the clk edge of the move_tick cycle; one-cycle registered output.

Test Plan (ball_width=10, wall_width=10, paddle_length=80, defaults otherwise; clamp range [10,390], center 200):
1. Assert reset mid-TRACK with paddle_y=300 -> paddle_y=200 and cpu_state=00 asynchronously, before the next clk edge.
2. From CENTER at 200, set ball_direction=0, ball_y=300, pulse move_tick every 4 clks:
   - state goes 01 and paddle_y stays 200 for 8 ticks;
   - then TRACK, paddle_y steps 203, 206, ...;
   - settles at 263 after 21 moves (err 2 <= DEADBAND).
3. TRACK with ball_y=470 -> target clamps to 390; paddle_y ramps by 3 per tick and stops at 388 (err 2); it never exceeds 390.
4. TRACK with ball_y=0 -> signed target -35 clamps to 10; paddle_y descends without underflow and stops within 4 of 10.
5. ball_direction 0->1 during REACT at counter=5 -> CENTER next clk, counter 0; paddle moves toward 200 on subsequent ticks.
6. Hold move_tick low for 100 clks in TRACK with a large err -> paddle_y unchanged; the first tick then moves exactly 3.
